// File: rtl/de_regfile_scoreboard.sv
// rtl/de_regfile_scoreboard.sv - decode-side register file with write bypass and pending-write scoreboard
module de_regfile_scoreboard #(
    parameter int REGWORDS = 32,
    parameter int DBITS    = 32,
    parameter int CNTBITS  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(REGWORDS)+DBITS:0] from_WB_to_DE,
    input  logic [$clog2(REGWORDS)-1:0] rs1_regno,
    input  logic [$clog2(REGWORDS)-1:0] rs2_regno,
    input  logic                        rs1_used,
    input  logic                        rs2_used,
    input  logic                        de_valid,
    input  logic                        de_wr_reg,
    input  logic [$clog2(REGWORDS)-1:0] de_rd_regno,
    input  logic                        agex_ready,
    output logic [DBITS-1:0]            rs1_val,
    output logic [DBITS-1:0]            rs2_val,
    output logic                        de_stall,
    output logic                        de_issue,
    output logic                        sb_err
);
    localparam int AW = $clog2(REGWORDS);
    localparam logic [CNTBITS-1:0] CNT_MAX = '1;

    logic [DBITS-1:0]   reg_q [REGWORDS];
    logic [DBITS-1:0]   reg_d [REGWORDS];
    logic [CNTBITS-1:0] cnt_q [REGWORDS];
    logic [CNTBITS-1:0] cnt_d [REGWORDS];
    logic               sb_err_q, sb_err_d;

    logic               wb_wr;
    logic [AW-1:0]      wb_no;
    logic [DBITS-1:0]   wb_val;
    logic [REGWORDS-1:0] retire, alloc, pending;
    logic               raw_hazard, sat_hazard;

    assign wb_wr  = from_WB_to_DE[AW+DBITS];
    assign wb_no  = from_WB_to_DE[AW+DBITS-1:DBITS];
    assign wb_val = from_WB_to_DE[DBITS-1:0];

    always_comb begin
        rs1_val = '0;
        if (rs1_regno != '0)
            rs1_val = (wb_wr && wb_no == rs1_regno) ? wb_val : reg_q[rs1_regno];
        rs2_val = '0;
        if (rs2_regno != '0)
            rs2_val = (wb_wr && wb_no == rs2_regno) ? wb_val : reg_q[rs2_regno];
    end

    // A register is still pending only if more writes are outstanding than retire this cycle;
    // an unallocated retire (underflow) must not raise a hazard.
    always_comb begin
        retire  = '0;
        pending = '0;
        for (int r = 1; r < REGWORDS; r++) begin
            retire[r]  = wb_wr && (wb_no == AW'(r));
            pending[r] = cnt_q[r] > CNTBITS'(retire[r]);
        end
        raw_hazard = (rs1_used && pending[rs1_regno]) || (rs2_used && pending[rs2_regno]);
        sat_hazard = de_wr_reg && (de_rd_regno != '0) &&
                     (cnt_q[de_rd_regno] == CNT_MAX) && !retire[de_rd_regno];
        de_stall   = de_valid && (raw_hazard || sat_hazard);
        de_issue   = de_valid && !de_stall && agex_ready;
        alloc      = '0;
        for (int r = 1; r < REGWORDS; r++)
            alloc[r] = de_issue && de_wr_reg && (de_rd_regno == AW'(r));
    end

    always_comb begin
        reg_d    = reg_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (wb_wr && wb_no != '0)
            reg_d[wb_no] = wb_val;
        for (int r = 1; r < REGWORDS; r++) begin
            case ({alloc[r], retire[r]})
                2'b10: cnt_d[r] = cnt_q[r] + CNTBITS'(1);
                2'b01: begin
                    if (cnt_q[r] == '0)
                        sb_err_d = 1'b1;
                    else
                        cnt_d[r] = cnt_q[r] - CNTBITS'(1);
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
        reg_d[0] = '0;
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q    <= '{default: '0};
            cnt_q    <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;
endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// tb/tb_de_regfile_scoreboard.sv - scoreboard bench for de_regfile_scoreboard
module tb_de_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] from_WB_to_DE = '0;
    logic [4:0]  rs1_regno = '0, rs2_regno = '0, de_rd_regno = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0, de_valid = 1'b0, de_wr_reg = 1'b0, agex_ready = 1'b0;
    logic [31:0] rs1_val, rs2_val;
    logic        de_stall, de_issue, sb_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        logic        is;
        logic        er;
    } exp_t;
    exp_t exp_q[$];

    de_regfile_scoreboard dut (
        .clk(clk), .reset(reset), .from_WB_to_DE(from_WB_to_DE),
        .rs1_regno(rs1_regno), .rs2_regno(rs2_regno),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .de_valid(de_valid), .de_wr_reg(de_wr_reg), .de_rd_regno(de_rd_regno),
        .agex_ready(agex_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .de_stall(de_stall), .de_issue(de_issue), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic wv, input logic [4:0] wn, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                        input logic dv, input logic dwr, input logic [4:0] rd, input logic ar,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic es, input logic ei, input logic ee);
        exp_t e;
        from_WB_to_DE = {wv, wn, wd};
        rs1_regno = a1; rs2_regno = a2; rs1_used = u1; rs2_used = u2;
        de_valid = dv; de_wr_reg = dwr; de_rd_regno = rd; agex_ready = ar;
        exp_q.push_back('{tag, e1, e2, es, ei, ee});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.tag, ".rs1"},   rs1_val, e.r1);
        chk({e.tag, ".rs2"},   rs2_val, e.r2);
        chk({e.tag, ".stall"}, {31'b0, de_stall}, {31'b0, e.st});
        chk({e.tag, ".issue"}, {31'b0, de_issue}, {31'b0, e.is});
        chk({e.tag, ".err"},   {31'b0, sb_err},   {31'b0, e.er});
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        //    tag          wv wn   wd            a1 a2 u1 u2 dv dwr rd ar  e1            e2            st is er
        step("rst",        0, 0,  32'h0,        5, 0, 0, 0, 1, 0,  0, 1, 32'h0,        32'h0,        0, 1, 0);
        step("alloc5",     0, 0,  32'h0,        5, 0, 0, 0, 1, 1,  5, 1, 32'h0,        32'h0,        0, 1, 0);
        step("byp5",       1, 5,  32'hDEADBEEF, 5, 0, 1, 0, 1, 0,  0, 1, 32'hDEADBEEF, 32'h0,        0, 1, 0);
        step("arr5",       0, 0,  32'h0,        5, 0, 1, 0, 1, 0,  0, 1, 32'hDEADBEEF, 32'h0,        0, 1, 0);
        step("wr_x0",      1, 0,  32'h1234,     0, 0, 1, 1, 0, 0,  0, 1, 32'h0,        32'h0,        0, 0, 0);
        step("rd_x0",      0, 0,  32'h0,        0, 5, 1, 1, 1, 0,  0, 1, 32'h0,        32'hDEADBEEF, 0, 1, 0);
        step("alloc7",     0, 0,  32'h0,        0, 0, 0, 0, 1, 1,  7, 1, 32'h0,        32'h0,        0, 1, 0);
        step("raw7",       0, 0,  32'h0,        7, 0, 1, 0, 1, 0,  0, 1, 32'h0,        32'h0,        1, 0, 0);
        step("raw7_nordy", 0, 0,  32'h0,        7, 0, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0);
        step("wb7",        1, 7,  32'h42,       7, 0, 1, 0, 1, 0,  0, 1, 32'h42,       32'h0,        0, 1, 0);
        step("nordy",      0, 0,  32'h0,        7, 0, 1, 0, 1, 0,  0, 0, 32'h42,       32'h0,        0, 0, 0);
        step("a3_1",       0, 0,  32'h0,        0, 0, 0, 0, 1, 1,  3, 1, 32'h0,        32'h0,        0, 1, 0);
        step("a3_2",       0, 0,  32'h0,        0, 0, 0, 0, 1, 1,  3, 1, 32'h0,        32'h0,        0, 1, 0);
        step("a3_3",       0, 0,  32'h0,        0, 0, 0, 0, 1, 1,  3, 1, 32'h0,        32'h0,        0, 1, 0);
        step("sat3",       0, 0,  32'h0,        0, 0, 0, 0, 1, 1,  3, 1, 32'h0,        32'h0,        1, 0, 0);
        step("sat3_wb",    1, 3,  32'h33,       3, 0, 0, 0, 1, 1,  3, 1, 32'h33,       32'h0,        0, 1, 0);
        step("sat3_again", 0, 0,  32'h0,        3, 0, 0, 0, 1, 1,  3, 1, 32'h33,       32'h0,        1, 0, 0);
        step("alloc4",     0, 0,  32'h0,        0, 0, 0, 0, 1, 1,  4, 1, 32'h0,        32'h0,        0, 1, 0);
        step("ar4",        1, 4,  32'h44,       4, 0, 0, 0, 1, 1,  4, 1, 32'h44,       32'h0,        0, 1, 0);
        step("raw4",       0, 0,  32'h0,        4, 0, 1, 0, 1, 0,  0, 1, 32'h44,       32'h0,        1, 0, 0);
        step("uf9",        1, 9,  32'h1,        0, 0, 0, 0, 0, 0,  0, 1, 32'h0,        32'h0,        0, 0, 0);
        step("uf9_err",    0, 0,  32'h0,        0, 0, 0, 0, 0, 0,  0, 1, 32'h0,        32'h0,        0, 0, 1);
        step("uf9_sticky", 0, 0,  32'h0,        9, 0, 1, 0, 1, 0,  0, 1, 32'h1,        32'h0,        0, 1, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        step("post_rst",   0, 0,  32'h0,        5, 9, 1, 1, 1, 0,  0, 1, 32'h0,        32'h0,        0, 1, 0);
        step("post_rst3",  0, 0,  32'h0,        7, 4, 1, 1, 1, 1,  3, 1, 32'h0,        32'h0,        0, 1, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
